// File: rtl/mips_pkg.sv
// Shared definitions for the MIPS front end: NOP encoding, reset PC,
// fetch-state encoding, the IF/ID payload record and address helpers.
package mips_pkg;

   // All-zero word decodes as sll $0,$0,0, the canonical MIPS NOP.
   localparam logic [31:0] MIPS_NOP         = 32'h0000_0000;

   // Default byte address of the first fetched instruction.
   localparam logic [31:0] PC_RESET_DEFAULT = 32'h0000_0000;

   // Fetch state encoding. Kept as plain constants so older tools and
   // hand-written netlists can use the same values.
   typedef logic [0:0] fetch_state_t;
   localparam logic [0:0] FS_RUN    = 1'b0;
   localparam logic [0:0] FS_HALTED = 1'b1;

   // Payload carried by the IF/ID pipeline register.
   typedef struct packed {
      logic [31:0] instr;
      logic [31:0] pc;
      logic [31:0] pc_plus4;
   } if_id_t;

   // Force a byte address onto a word boundary.
   function automatic logic [31:0] word_align(input logic [31:0] addr);
      return {addr[31:2], 2'b00};
   endfunction

   // True when a byte address does not sit on a word boundary.
   function automatic logic is_misaligned(input logic [31:0] addr);
      return |addr[1:0];
   endfunction

endpackage : mips_pkg

// File: rtl/if_id_reg.sv
// IF/ID pipeline register. Bubble wins over load; with neither asserted the
// register holds, which is how a stall is realised.
module if_id_reg
   import mips_pkg::*;
(
   input  logic   clk,
   input  logic   rst,
   input  logic   i_load,
   input  logic   i_bubble,
   input  if_id_t i_data,
   output if_id_t o_data,
   output logic   o_valid
);

   if_id_t r_data;
   logic   r_valid;

   // Capture a new instruction, squash to a NOP bubble, or hold.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_data.instr    <= MIPS_NOP;
         r_data.pc       <= 32'h0;
         r_data.pc_plus4 <= 32'h0;
         r_valid         <= 1'b0;
      end else if (i_bubble) begin
         // Only the instruction word is cleared; the PC fields keep their
         // last value since decode ignores them while valid is low.
         r_data.instr <= MIPS_NOP;
         r_valid      <= 1'b0;
      end else if (i_load) begin
         r_data  <= i_data;
         r_valid <= 1'b1;
      end
   end

   assign o_data  = r_data;
   assign o_valid = r_valid;

endmodule : if_id_reg

// File: rtl/instr_fetch_unit.sv
// Fetch stage: owns the PC, addresses the instruction ROM combinationally and
// registers the returned word into IF/ID. Control priority is reset, halt,
// redirect, flush, stall, then sequential fetch.
module instr_fetch_unit
   import mips_pkg::*;
#(
   parameter logic [31:0] PC_RESET = PC_RESET_DEFAULT,
   parameter int          ROM_AW   = 10
)
(
   input  logic              clk,
   input  logic              rst,
   input  logic              stall,
   input  logic              flush,
   input  logic              redirect_valid,
   input  logic [31:0]       redirect_target,
   input  logic              halt,
   output logic [ROM_AW-1:0] rom_addr,
   input  logic [31:0]       rom_data_in,
   output logic [31:0]       if_instr,
   output logic [31:0]       if_pc,
   output logic [31:0]       if_pc_plus4,
   output logic              if_valid,
   output logic [31:0]       pc_out,
   output logic              misalign_err
);

   fetch_state_t r_state;
   logic [31:0]  r_pc;
   logic         r_misalign;

   fetch_state_t w_state_next;
   logic [31:0]  w_pc_next;
   logic [31:0]  w_pc_plus4;
   logic         w_if_load;
   logic         w_if_bubble;
   logic         w_misalign_set;
   if_id_t       w_if_in;
   if_id_t       w_if_out;

   // Sequential successor; wraps modulo 2^32 by construction.
   assign w_pc_plus4 = r_pc + 32'd4;

   // Next-state, next-PC and IF/ID control decode in priority order.
   always_comb begin
      w_state_next   = r_state;
      w_pc_next      = r_pc;
      w_if_load      = 1'b0;
      w_if_bubble    = 1'b0;
      w_misalign_set = 1'b0;

      if (r_state == FS_HALTED) begin
         // Frozen until reset; every other control input is ignored.
         w_if_bubble = 1'b1;
      end else if (halt) begin
         // The word being fetched this cycle is dropped and the PC is not
         // updated, even when a redirect arrives in the same cycle.
         w_state_next = FS_HALTED;
         w_if_bubble  = 1'b1;
      end else if (redirect_valid) begin
         // Redirect overrides stall: the target is taken regardless.
         w_pc_next      = word_align(redirect_target);
         w_if_bubble    = 1'b1;
         w_misalign_set = is_misaligned(redirect_target);
      end else if (flush) begin
         w_if_bubble = 1'b1;
         if (!stall) begin
            w_pc_next = w_pc_plus4;
         end
      end else if (!stall) begin
         w_pc_next = w_pc_plus4;
         w_if_load = 1'b1;
      end
   end

   // PC, fetch state and sticky misalignment flag.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_pc       <= word_align(PC_RESET);
         r_state    <= FS_RUN;
         r_misalign <= 1'b0;
      end else begin
         r_pc    <= w_pc_next;
         r_state <= w_state_next;
         if (w_misalign_set) begin
            r_misalign <= 1'b1;
         end
      end
   end

   // The ROM is word addressed; upper PC bits are dropped so fetch wraps.
   assign rom_addr = r_pc[ROM_AW+1:2];

   assign w_if_in.instr    = rom_data_in;
   assign w_if_in.pc       = r_pc;
   assign w_if_in.pc_plus4 = w_pc_plus4;

   if_id_reg u_if_id (
      .clk      (clk),
      .rst      (rst),
      .i_load   (w_if_load),
      .i_bubble (w_if_bubble),
      .i_data   (w_if_in),
      .o_data   (w_if_out),
      .o_valid  (if_valid)
   );

   assign if_instr     = w_if_out.instr;
   assign if_pc        = w_if_out.pc;
   assign if_pc_plus4  = w_if_out.pc_plus4;
   assign pc_out       = r_pc;
   assign misalign_err = r_misalign;

endmodule : instr_fetch_unit

// File: tb/tb_instr_fetch_unit.sv
// Directed bench for instr_fetch_unit. A behavioural ROM returns
// 0x1000_0000 + word address. A table of per-edge vectors covers sequential
// fetch, stall, flush, redirect, misalignment and wrap; halt and reset
// recovery are hand-written sequences.
module tb_instr_fetch_unit;

   logic        clk = 1'b0;
   logic        rst;
   logic        stall;
   logic        flush;
   logic        redirect_valid;
   logic [31:0] redirect_target;
   logic        halt;
   logic [9:0]  rom_addr;
   logic [31:0] rom_data_in;
   logic [31:0] if_instr;
   logic [31:0] if_pc;
   logic [31:0] if_pc_plus4;
   logic        if_valid;
   logic [31:0] pc_out;
   logic        misalign_err;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   assign rom_data_in = 32'h1000_0000 + {22'd0, rom_addr};

   instr_fetch_unit dut (
      .clk             (clk),
      .rst             (rst),
      .stall           (stall),
      .flush           (flush),
      .redirect_valid  (redirect_valid),
      .redirect_target (redirect_target),
      .halt            (halt),
      .rom_addr        (rom_addr),
      .rom_data_in     (rom_data_in),
      .if_instr        (if_instr),
      .if_pc           (if_pc),
      .if_pc_plus4     (if_pc_plus4),
      .if_valid        (if_valid),
      .pc_out          (pc_out),
      .misalign_err    (misalign_err)
   );

   typedef struct {
      logic        stall;
      logic        flush;
      logic        redir;
      logic [31:0] target;
      logic [31:0] exp_pc;
      logic [9:0]  exp_rom;
      logic        exp_valid;
      logic [31:0] exp_instr;
      logic [31:0] exp_if_pc;
      logic [31:0] exp_pc4;
      logic        exp_mis;
   } vec_t;

   vec_t vq[$];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
      end
   endtask

   // One rising edge, then settle 1 ns so outputs are sampled off the edge.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs();
      stall = 0; flush = 0; redirect_valid = 0; redirect_target = 32'h0; halt = 0;
   endtask

   initial begin
      // stall flush redir target | pc rom valid instr if_pc pc4 mis
      vq.push_back('{0,0,0,32'h0,   32'h4,   10'd1,  1,32'h1000_0000,32'h0,   32'h4,   0}); // T1
      vq.push_back('{0,0,0,32'h0,   32'h8,   10'd2,  1,32'h1000_0001,32'h4,   32'h8,   0});
      vq.push_back('{1,0,0,32'h0,   32'h8,   10'd2,  1,32'h1000_0001,32'h4,   32'h8,   0}); // T2
      vq.push_back('{1,0,0,32'h0,   32'h8,   10'd2,  1,32'h1000_0001,32'h4,   32'h8,   0});
      vq.push_back('{1,0,0,32'h0,   32'h8,   10'd2,  1,32'h1000_0001,32'h4,   32'h8,   0});
      vq.push_back('{0,0,0,32'h0,   32'hC,   10'd3,  1,32'h1000_0002,32'h8,   32'hC,   0});
      vq.push_back('{0,0,0,32'h0,   32'h10,  10'd4,  1,32'h1000_0003,32'hC,   32'h10,  0});
      vq.push_back('{0,1,0,32'h0,   32'h14,  10'd5,  0,32'h0,        32'h0,   32'h0,   0}); // T4
      vq.push_back('{0,0,0,32'h0,   32'h18,  10'd6,  1,32'h1000_0005,32'h14,  32'h18,  0});
      vq.push_back('{1,0,1,32'h40,  32'h40,  10'd16, 0,32'h0,        32'h0,   32'h0,   0}); // T3
      vq.push_back('{0,0,0,32'h0,   32'h44,  10'd17, 1,32'h1000_0010,32'h40,  32'h44,  0});
      vq.push_back('{0,0,1,32'hFFE, 32'hFFC, 10'd1023,0,32'h0,       32'h0,   32'h0,   1}); // T5
      vq.push_back('{0,0,0,32'h0,   32'h1000,10'd0,  1,32'h1000_03FF,32'hFFC, 32'h1000,1});
      vq.push_back('{0,0,0,32'h0,   32'h1004,10'd1,  1,32'h1000_0000,32'h1000,32'h1004,1});
      vq.push_back('{0,0,1,32'hFFFF_FFFC,32'hFFFF_FFFC,10'd1023,0,32'h0,32'h0, 32'h0,   1}); // 2^32 wrap
      vq.push_back('{0,0,0,32'h0,   32'h0,   10'd0,  1,32'h1000_03FF,32'hFFFF_FFFC,32'h0,1});
      vq.push_back('{1,1,0,32'h0,   32'h0,   10'd0,  0,32'h0,        32'h0,   32'h0,   1}); // flush+stall
      vq.push_back('{0,0,0,32'h0,   32'h4,   10'd1,  1,32'h1000_0000,32'h0,   32'h4,   1});
      vq.push_back('{0,0,1,32'h20,  32'h20,  10'd8,  0,32'h0,        32'h0,   32'h0,   1}); // to 0x20

      idle_inputs();
      rst = 1;
      step();
      step();
      check("reset_pc",       pc_out,                    32'h0);
      check("reset_valid",    {31'd0, if_valid},         32'h0);
      check("reset_instr",    if_instr,                  32'h0);
      check("reset_if_pc",    if_pc,                     32'h0);
      check("reset_pc4",      if_pc_plus4,               32'h0);
      check("reset_misalign", {31'd0, misalign_err},     32'h0);
      rst = 0;
      #1;
      check("first_cycle_valid", {31'd0, if_valid},      32'h0);
      $display("reset: pc=0x%08h valid=%0b", pc_out, if_valid);

      for (int i = 0; i < vq.size(); i++) begin
         stall           = vq[i].stall;
         flush           = vq[i].flush;
         redirect_valid  = vq[i].redir;
         redirect_target = vq[i].target;
         step();
         check($sformatf("v%0d_pc", i),       pc_out,                vq[i].exp_pc);
         check($sformatf("v%0d_rom", i),      {22'd0, rom_addr},     {22'd0, vq[i].exp_rom});
         check($sformatf("v%0d_valid", i),    {31'd0, if_valid},     {31'd0, vq[i].exp_valid});
         check($sformatf("v%0d_instr", i),    if_instr,              vq[i].exp_instr);
         check($sformatf("v%0d_misalign", i), {31'd0, misalign_err}, {31'd0, vq[i].exp_mis});
         if (vq[i].exp_valid) begin
            check($sformatf("v%0d_if_pc", i),  if_pc,       vq[i].exp_if_pc);
            check($sformatf("v%0d_if_pc4", i), if_pc_plus4, vq[i].exp_pc4);
         end
         $display("vec %0d: st=%0b fl=%0b rd=%0b tgt=0x%08h -> pc=0x%08h valid=%0b instr=0x%08h if_pc=0x%08h mis=%0b",
                  i, vq[i].stall, vq[i].flush, vq[i].redir, vq[i].target,
                  pc_out, if_valid, if_instr, if_pc, misalign_err);
      end

      // T6: halt together with a redirect; halt wins and pc stays put.
      idle_inputs();
      halt = 1; redirect_valid = 1; redirect_target = 32'h80;
      step();
      check("halt_pc",    pc_out,            32'h20);
      check("halt_valid", {31'd0, if_valid}, 32'h0);
      check("halt_instr", if_instr,          32'h0);
      $display("halt: pc=0x%08h valid=%0b", pc_out, if_valid);

      // Halt released but the unit stays frozen; controls are ignored.
      for (int k = 0; k < 4; k++) begin
         idle_inputs();
         stall = (k == 1);
         flush = (k == 2);
         redirect_valid = (k == 3);
         redirect_target = 32'h100;
         step();
         check($sformatf("halted%0d_pc", k),    pc_out,            32'h20);
         check($sformatf("halted%0d_valid", k), {31'd0, if_valid}, 32'h0);
         check($sformatf("halted%0d_instr", k), if_instr,          32'h0);
         $display("halted %0d: pc=0x%08h valid=%0b", k, pc_out, if_valid);
      end

      // Only reset restarts fetch.
      idle_inputs();
      rst = 1;
      step();
      check("rst2_pc",       pc_out,                32'h0);
      check("rst2_misalign", {31'd0, misalign_err}, 32'h0);
      rst = 0;
      step();
      check("restart_pc",    pc_out,            32'h4);
      check("restart_valid", {31'd0, if_valid}, 32'h1);
      check("restart_instr", if_instr,          32'h1000_0000);
      check("restart_if_pc", if_pc,             32'h0);
      $display("restart: pc=0x%08h valid=%0b instr=0x%08h", pc_out, if_valid, if_instr);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule : tb_instr_fetch_unit
